gf180mcu_fd_io__bidir_seq: RTL

Core-side sequencer for a bidirectional GF180MCU I/O pad. It drives the pad's output-enable, input-enable and output data, and enforces a fixed bus-turnaround gap whenever the core switches the pad between drive and receive. In receive mode it synchronizes and deglitches the asynchronous pad input before handing it to the core. It sits between core logic and the pad-ring bidir cell, one instance per pad.

---
 rtl/gf180mcu_fd_io__pkg.sv | 16 +
 rtl/gf180mcu_fd_io__in_filt.sv | 78 +++++++
 rtl/gf180mcu_fd_io__bidir_seq.sv | 110 +++++++++++
 3 files changed

// File: rtl/gf180mcu_fd_io__pkg.sv
// Shared types and parameter limits for the GF180MCU bidirectional pad sequencer.
package gf180mcu_fd_io__pkg;

    typedef enum logic [1:0] {
        RX     = 2'd0,
        GAP_TX = 2'd1,
        TX     = 2'd2,
        GAP_RX = 2'd3
    } state_t;

    localparam int TURN_CYC_MAX = 15;
    localparam int FILT_LEN_MAX = 15;
    localparam int SYNC_MIN     = 2;
    localparam int SYNC_MAX     = 4;

endpackage

// File: rtl/gf180mcu_fd_io__in_filt.sv
// Receive path: synchronizes the asynchronous pad input, deglitches it with a
// candidate/count filter and qualifies the result only while receiving.
module gf180mcu_fd_io__in_filt
    import gf180mcu_fd_io__pkg::*;
#(
    parameter int FILT_LEN    = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic pad_y,
    output logic din,
    output logic din_valid,
    output logic din_edge
);

    localparam logic [3:0] FILT_CNT = 4'(FILT_LEN);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;
    logic                   cand;
    logic                   cand_next;
    logic [3:0]             cnt;
    logic [3:0]             cnt_next;
    logic                   qual;
    logic                   valid_q;

    assign sample = sync_q[SYNC_STAGES-1];

    // Synchronizer chain runs in every state so a fresh level is ready on re-entry to RX.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_y};
        end
    end

    // Candidate/count update: a count of 0 means no agreeing samples yet, and outside RX the count is held at 0.
    always_comb begin
        cand_next = cand;
        cnt_next  = cnt;
        if (!en) begin
            cnt_next = 4'd0;
        end else if (cnt == 4'd0 || sample != cand) begin
            cand_next = sample;
            cnt_next  = 4'd1;
        end else if (cnt != FILT_CNT) begin
            cnt_next = cnt + 4'd1;
        end
        qual = en && (cnt_next == FILT_CNT);
    end

    // Filter state and qualified outputs; DIN only moves once FILT_LEN samples agree, and it holds its value outside RX.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand     <= 1'b0;
            cnt      <= 4'd0;
            din      <= 1'b0;
            valid_q  <= 1'b0;
            din_edge <= 1'b0;
        end else begin
            cand     <= cand_next;
            cnt      <= cnt_next;
            din_edge <= qual && valid_q && (cand_next != din);
            if (qual) begin
                din     <= cand_next;
                valid_q <= 1'b1;
            end else if (!en) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign din_valid = valid_q && en;

endmodule

// File: rtl/gf180mcu_fd_io__bidir_seq.sv
// Core-side sequencer for a bidirectional pad: direction FSM with fixed
// turnaround gaps, registered output data, and the filtered receive path.
module gf180mcu_fd_io__bidir_seq
    import gf180mcu_fd_io__pkg::*;
#(
    parameter int TURN_CYC    = 2,
    parameter int FILT_LEN    = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic DIR_REQ,
    input  logic DOUT,
    output logic DIN,
    output logic DIN_VALID,
    output logic DIN_EDGE,
    output logic DIR_ACK,
    output logic BUSY,
    output logic PAD_A,
    output logic PAD_OE,
    output logic PAD_IE,
    input  logic PAD_Y
);

    localparam logic [3:0] GAP_LOAD = 4'(TURN_CYC - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] gap_cnt;
    logic [3:0] gap_cnt_next;
    logic       pad_a_q;

    // State and gap counter register; reset drops straight to RX without a gap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= RX;
            gap_cnt <= 4'd0;
        end else begin
            state   <= state_next;
            gap_cnt <= gap_cnt_next;
        end
    end

    // Next-state logic: a gap always runs to completion and ignores DIR_REQ; settled states react to DIR_REQ immediately.
    always_comb begin
        state_next   = state;
        gap_cnt_next = gap_cnt;
        case (state)
            RX: begin
                if (DIR_REQ) begin
                    state_next   = GAP_TX;
                    gap_cnt_next = GAP_LOAD;
                end
            end
            GAP_TX: begin
                if (gap_cnt == 4'd0) begin
                    state_next = TX;
                end else begin
                    gap_cnt_next = gap_cnt - 4'd1;
                end
            end
            TX: begin
                if (!DIR_REQ) begin
                    state_next   = GAP_RX;
                    gap_cnt_next = GAP_LOAD;
                end
            end
            GAP_RX: begin
                if (gap_cnt == 4'd0) begin
                    state_next = RX;
                end else begin
                    gap_cnt_next = gap_cnt - 4'd1;
                end
            end
            default: begin
                state_next   = RX;
                gap_cnt_next = 4'd0;
            end
        endcase
    end

    // Output data register: follows DOUT only on edges that land in TX, so the pad sees 0 everywhere else.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pad_a_q <= 1'b0;
        end else begin
            pad_a_q <= (state_next == TX) ? DOUT : 1'b0;
        end
    end

    assign PAD_A   = pad_a_q;
    assign PAD_OE  = (state == TX);
    assign PAD_IE  = (state == RX);
    assign DIR_ACK = (state == TX);
    assign BUSY    = (state == GAP_TX) || (state == GAP_RX);

    gf180mcu_fd_io__in_filt #(
        .FILT_LEN    (FILT_LEN),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_filt (
        .clk       (CLK),
        .rst       (RST),
        .en        (state == RX),
        .pad_y     (PAD_Y),
        .din       (DIN),
        .din_valid (DIN_VALID),
        .din_edge  (DIN_EDGE)
    );

endmodule
